// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one external combinational ALU between two requesters.
// Optional sticky V/C flag tracking is built when STICKY_FLAGS_EN is defined.
module alu_rr_sequencer #(
    parameter int WIDTH       = 32,
    parameter int CTRL_W      = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [WIDTH-1:0]  r0_a,
    input  logic [WIDTH-1:0]  r0_b,
    input  logic [CTRL_W-1:0] r0_ctrl,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [WIDTH-1:0]  r1_a,
    input  logic [WIDTH-1:0]  r1_b,
    input  logic [CTRL_W-1:0] r1_ctrl,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_verflow,
    input  logic              alu_carry,
    input  logic              alu_negative,
    input  logic              alu_zero,
`ifdef STICKY_FLAGS_EN
    input  logic              sticky_clr,
    output logic [1:0]        sticky_vc,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_result,
    output logic [3:0]        rsp_flags
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    logic [1:0] state;
    logic       last_grant;
    logic       grant;
    logic       op_id;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;

    // A tie goes to whichever requester was not served last.
    always_comb begin
        grant = 1'b0;
        if (r0_valid && r1_valid) begin
            grant = ~last_grant;
        end else if (r1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is gated by reset so no handshake can appear while rst_n is held low.
    assign r0_ready  = rst_n && (state == IDLE) && r0_valid && !grant;
    assign r1_ready  = rst_n && (state == IDLE) && r1_valid && grant;
    assign accept    = r0_ready || r1_ready;
    assign capture   = (state == EXEC) && (cnt == 4'd0);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            op_id       <= 1'b0;
            cnt         <= 4'd0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a       <= grant ? r1_a : r0_a;
                        alu_b       <= grant ? r1_b : r0_b;
                        alu_control <= grant ? r1_ctrl : r0_ctrl;
                        op_id       <= grant;
                        last_grant  <= grant;
                        cnt         <= CNT_INIT;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (capture) begin
                        rsp_result <= alu_result;
                        rsp_flags  <= {alu_verflow, alu_carry, alu_negative, alu_zero};
                        rsp_id     <= op_id;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STICKY_FLAGS_EN
    // A flag seen at capture beats a clear requested in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_vc <= 2'b00;
        end else begin
            if (capture && alu_verflow) begin
                sticky_vc[1] <= 1'b1;
            end else if (sticky_clr) begin
                sticky_vc[1] <= 1'b0;
            end
            if (capture && alu_carry) begin
                sticky_vc[0] <= 1'b1;
            end else if (sticky_clr) begin
                sticky_vc[0] <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed self-checking bench for alu_rr_sequencer with a behavioural add/sub ALU stub.
// Sticky-flag checks are compiled in only when STICKY_FLAGS_EN is defined.
module tb_alu_rr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [2:0]  r0_ctrl, r1_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_control;
    logic        alu_verflow, alu_carry, alu_negative, alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
`ifdef STICKY_FLAGS_EN
    logic        sticky_clr;
    logic [1:0]  sticky_vc;
`endif

    int total = 0;
    int bad   = 0;

    alu_rr_sequencer #(.WIDTH(32), .CTRL_W(3), .EXEC_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_ctrl(r0_ctrl),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_ctrl(r1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_verflow(alu_verflow), .alu_carry(alu_carry),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
`ifdef STICKY_FLAGS_EN
        .sticky_clr(sticky_clr), .sticky_vc(sticky_vc),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: carry on subtract means borrow; unknown codes act as bitwise AND.
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum     = 33'd0;
        alu_verflow = 1'b0;
        case (alu_control)
            3'b000: begin
                alu_sum     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_verflow = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            3'b001: begin
                alu_sum     = {1'b0, alu_a} - {1'b0, alu_b};
                alu_verflow = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            default: alu_sum = {1'b0, alu_a & alu_b};
        endcase
        alu_result   = alu_sum[31:0];
        alu_carry    = alu_sum[32];
        alu_negative = alu_sum[31];
        alu_zero     = (alu_sum[31:0] == 32'd0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic id, input logic valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] ctrl);
        if (id) begin
            r1_valid = valid; r1_a = a; r1_b = b; r1_ctrl = ctrl;
        end else begin
            r0_valid = valid; r0_a = a; r0_b = b; r0_ctrl = ctrl;
        end
    endtask

    // One isolated op: accept, exec, response with immediate consumer ready.
    task automatic runOp(input string tag, input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ctrl, input logic [31:0] exp_res, input logic [3:0] exp_flags);
        @(negedge clk);
        applyStimulus(id, 1'b1, a, b, ctrl);
        #1;
        checkOutput({tag, "_ready"}, id ? r1_ready : r0_ready, 1);
        checkOutput({tag, "_other_ready"}, id ? r0_ready : r1_ready, 0);
        @(negedge clk);
        applyStimulus(id, 1'b0, a, b, ctrl);
        #1;
        checkOutput({tag, "_alu_a"}, alu_a, a);
        checkOutput({tag, "_alu_b"}, alu_b, b);
        checkOutput({tag, "_alu_ctrl"}, alu_control, ctrl);
        checkOutput({tag, "_early_rsp"}, rsp_valid, 0);
        @(negedge clk);
        #1;
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 1);
        checkOutput({tag, "_rsp_id"}, rsp_id, id);
        checkOutput({tag, "_rsp_result"}, rsp_result, exp_res);
        checkOutput({tag, "_rsp_flags"}, rsp_flags, exp_flags);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checkOutput({tag, "_rsp_done"}, rsp_valid, 0);
    endtask

    logic        exp_g;
    logic        gq[$];
    logic [31:0] rq[$];
    int          acc0, acc1, nrsp;

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'd0, 32'd0, 3'd0);
        applyStimulus(1'b1, 1'b1, 32'd0, 32'd0, 3'd0);
`ifdef STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_r0_ready", r0_ready, 0);
        checkOutput("rst_r1_ready", r1_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_rsp_result", rsp_result, 0);
        checkOutput("rst_rsp_flags", rsp_flags, 0);
`ifdef STICKY_FLAGS_EN
        checkOutput("rst_sticky", sticky_vc, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters stream four adds each; grants must alternate starting with r0.
        rsp_ready = 1'b1;
        exp_g = 1'b0;
        acc0 = 0; acc1 = 0; nrsp = 0;
        for (int cyc = 0; cyc < 200 && nrsp < 8; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (acc0 == 4) r0_valid = 1'b0;
            if (acc1 == 4) r1_valid = 1'b0;
            r0_a = 32'(acc0); r0_b = 32'd1;
            r1_a = 32'(100 + acc1); r1_b = 32'd1;
            #1;
            checkOutput("rr_one_ready", {31'd0, r0_ready & r1_ready}, 0);
            if (rsp_valid) begin
                if (gq.size() == 0) begin
                    checkOutput("rr_unexpected_rsp", 1, 0);
                end else begin
                    checkOutput("rr_rsp_id", rsp_id, gq.pop_front());
                    checkOutput("rr_rsp_result", rsp_result, rq.pop_front());
                end
                nrsp++;
            end
            if (r0_ready || r1_ready) begin
                checkOutput("rr_grant", r1_ready, exp_g);
                exp_g = ~exp_g;
                gq.push_back(r1_ready);
                rq.push_back(r1_ready ? r1_a + r1_b : r0_a + r0_b);
                if (r1_ready) acc1++; else acc0++;
            end
        end
        checkOutput("rr_rsp_count", nrsp, 8);
        checkOutput("rr_acc0", acc0, 4);
        checkOutput("rr_acc1", acc1, 4);
        @(negedge clk);
        rsp_ready = 1'b0;
        r0_valid = 1'b0;
        r1_valid = 1'b0;

        runOp("add", 1'b0, 32'd50, 32'd60, 3'b000, 32'd110, 4'b0000);
        runOp("sub", 1'b1, 32'h3C, 32'h3C, 3'b001, 32'd0, 4'b0001);
`ifdef STICKY_FLAGS_EN
        checkOutput("sticky_quiet", sticky_vc, 2'b00);
`endif
        runOp("ovf", 1'b0, 32'h8000_0000, 32'h8000_0001, 3'b000, 32'h0000_0001, 4'b1100);
`ifdef STICKY_FLAGS_EN
        repeat (3) @(negedge clk);
        #1;
        checkOutput("sticky_set", sticky_vc, 2'b11);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        #1;
        checkOutput("sticky_clr", sticky_vc, 2'b00);
`endif

        // Consumer stalls for 10 cycles while r0 waits behind the pending response.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'd7, 32'd8, 3'b000);
        #1;
        checkOutput("bp_r1_ready", r1_ready, 1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'd7, 32'd8, 3'b000);
        applyStimulus(1'b0, 1'b1, 32'd1, 32'd2, 3'b000);
        #1;
        checkOutput("bp_exec_no_ready", r0_ready, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_hold_valid", rsp_valid, 1);
            checkOutput("bp_hold_result", rsp_result, 15);
            checkOutput("bp_hold_id", rsp_id, 1);
            checkOutput("bp_hold_no_ready", r0_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checkOutput("bp_released", rsp_valid, 0);
        checkOutput("bp_next_accept", r0_ready, 1);
        @(negedge clk);
        r0_valid = 1'b0;
        #1;
        checkOutput("bp_next_alu_a", alu_a, 1);
        @(negedge clk);
        #1;
        checkOutput("bp_next_result", rsp_result, 3);
        checkOutput("bp_next_id", rsp_id, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset lands mid-EXEC with both requesters waiting.
        applyStimulus(1'b0, 1'b1, 32'd5, 32'd6, 3'b010);
        #1;
        checkOutput("rx_accept", r0_ready, 1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'd9, 32'd9, 3'b000);
        #1;
        checkOutput("rx_exec_ctrl", alu_control, 3'b010);
        rst_n = 1'b0;
        #1;
        checkOutput("rx_alu_a", alu_a, 0);
        checkOutput("rx_alu_b", alu_b, 0);
        checkOutput("rx_alu_ctrl", alu_control, 0);
        checkOutput("rx_rsp_result", rsp_result, 0);
        checkOutput("rx_rsp_valid", rsp_valid, 0);
        checkOutput("rx_r0_ready", r0_ready, 0);
        checkOutput("rx_r1_ready", r1_ready, 0);
        @(negedge clk);
        #1;
        checkOutput("rx_no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rx_tie_r0", r0_ready, 1);
        checkOutput("rx_tie_r1", r1_ready, 0);
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rx_rsp_valid_after", rsp_valid, 1);
        checkOutput("rx_rsp_result_after", rsp_result, 4);
        checkOutput("rx_rsp_id_after", rsp_id, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
